// File: rtl/mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// mem_req_arbiter
//
// Purpose:
//   Shares the core's single SRAM-like memory request port between the
//   instruction fetch stage (inst) and the data memory stage (data). One
//   requester is granted per request handshake, and the grant is held until
//   bus_addr_ok. The owner of every accepted request is recorded in an
//   in-order tag FIFO, so each bus_data_ok / bus_rdata is routed back to the
//   side that issued it. Request and response paths are purely
//   combinational, so neither adds a cycle of latency.
//
// Parameters:
//   MAX_OUTSTANDING  accepted-but-unanswered request limit (tag FIFO depth,
//                    power of 2, >= 2)
//   STARVE_LIMIT     consecutive lost arbitrations after which inst wins
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_*                      fetch request / response channel
//   data_*                      data-stage request / response channel
//   bus_*                       merged channel toward the cache / AXI bridge
//   proto_err                   sticky: bus_data_ok seen with no outstanding
//                               request
//   perfcnt_arb_conflict        IDLE cycles with both sides requesting
// ---------------------------------------------------------------------------
module mem_req_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_cache,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_cache,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_cache,
  input  logic        bus_addr_ok,
  input  logic [31:0] bus_rdata,
  input  logic        bus_data_ok,

  output logic        proto_err,
  output logic [31:0] perfcnt_arb_conflict
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_t;

  state_t state;

  // Tag FIFO: one bit per slot, 0 = inst owns the request, 1 = data owns it.
  logic [MAX_OUTSTANDING-1:0] tag_fifo;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [STV_W-1:0]           starve_cnt;

  logic issue_ok;
  logic grant_inst;
  logic grant_data;
  logic handshake;
  logic push;
  logic pop;
  logic head_tag;

  // Grant selection. A simultaneous pop frees a slot, so a full FIFO can
  // still issue in the cycle the oldest response returns. While reset is
  // asserted nothing is granted, so the request side goes quiet at once.
  always_comb begin
    issue_ok   = resetn && ((count < CNT_MAX) || bus_data_ok);
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state)
      IDLE: begin
        if (issue_ok) begin
          if (inst_req && data_req) begin
            if (starve_cnt == STV_MAX) grant_inst = 1'b1;
            else                       grant_data = 1'b1;
          end else if (inst_req) begin
            grant_inst = 1'b1;
          end else if (data_req) begin
            grant_data = 1'b1;
          end
        end
      end
      HOLD_I:  grant_inst = 1'b1;
      HOLD_D:  grant_data = 1'b1;
      default: begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
      end
    endcase
  end

  // Merged request channel. The inst side has no store data, so its payload
  // is fixed to a word-sized read.
  always_comb begin
    bus_req      = issue_ok && ((grant_inst && inst_req) || (grant_data && data_req));
    handshake    = bus_req && bus_addr_ok;
    inst_addr_ok = handshake && grant_inst;
    data_addr_ok = handshake && grant_data;
    push         = handshake;
    if (grant_data) begin
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
      bus_cache = data_cache;
    end else begin
      bus_wr    = 1'b0;
      bus_size  = 2'd2;
      bus_addr  = inst_addr;
      bus_wdata = 32'd0;
      bus_cache = inst_cache;
    end
  end

  // Response routing: the FIFO head says who owns the returning beat. A
  // response with nothing outstanding is dropped (and flagged below).
  always_comb begin
    pop          = resetn && bus_data_ok && (count != '0);
    head_tag     = tag_fifo[rd_ptr];
    inst_data_ok = pop && !head_tag;
    data_data_ok = pop && head_tag;
    inst_rdata   = bus_rdata;
    data_rdata   = bus_rdata;
  end

  // Grant-lock FSM. A grant that does not handshake immediately is locked so
  // the payload stays stable until bus_addr_ok. If the held side withdraws
  // its request, the lock is released rather than waiting forever.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_inst && !handshake)      state <= HOLD_I;
          else if (grant_data && !handshake) state <= HOLD_D;
          else                               state <= IDLE;
        end
        HOLD_I: if (handshake || !inst_req) state <= IDLE;
        HOLD_D: if (handshake || !data_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag FIFO bookkeeping. A push and pop in the same cycle leave the count
  // unchanged; issue_ok guarantees count never exceeds MAX_OUTSTANDING.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_fifo <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tag_fifo[wr_ptr] <= grant_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Starvation guard: counts IDLE cycles in which data beat a waiting inst
  // request, and is cleared as soon as inst gets through.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (inst_addr_ok) begin
      starve_cnt <= '0;
    end else if ((state == IDLE) && grant_data && inst_req && (starve_cnt != STV_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Sticky protocol error and the arbitration-conflict performance counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proto_err            <= 1'b0;
      perfcnt_arb_conflict <= 32'd0;
    end else begin
      if (bus_data_ok && (count == '0)) begin
        proto_err <= 1'b1;
      end
      if ((state == IDLE) && inst_req && data_req) begin
        perfcnt_arb_conflict <= perfcnt_arb_conflict + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_req_arbiter
//
// Purpose:
//   Directed, self-checking bench for mem_req_arbiter (MAX_OUTSTANDING=4,
//   STARVE_LIMIT=4). Inputs are driven one settle step after each rising
//   edge and outputs are checked mid-cycle; every expected value is a
//   hand-computed constant.
// ---------------------------------------------------------------------------
module tb_mem_req_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic        inst_cache;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_cache;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_cache;
  logic        bus_addr_ok;
  logic [31:0] bus_rdata;
  logic        bus_data_ok;
  logic        proto_err;
  logic [31:0] perfcnt_arb_conflict;

  int tests_run;
  int tests_failed;

  mem_req_arbiter #(
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT   (4)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .inst_req            (inst_req),
    .inst_cache          (inst_cache),
    .inst_addr           (inst_addr),
    .inst_addr_ok        (inst_addr_ok),
    .inst_rdata          (inst_rdata),
    .inst_data_ok        (inst_data_ok),
    .data_req            (data_req),
    .data_wr             (data_wr),
    .data_size           (data_size),
    .data_addr           (data_addr),
    .data_wdata          (data_wdata),
    .data_cache          (data_cache),
    .data_addr_ok        (data_addr_ok),
    .data_rdata          (data_rdata),
    .data_data_ok        (data_data_ok),
    .bus_req             (bus_req),
    .bus_wr              (bus_wr),
    .bus_size            (bus_size),
    .bus_addr            (bus_addr),
    .bus_wdata           (bus_wdata),
    .bus_cache           (bus_cache),
    .bus_addr_ok         (bus_addr_ok),
    .bus_rdata           (bus_rdata),
    .bus_data_ok         (bus_data_ok),
    .proto_err           (proto_err),
    .perfcnt_arb_conflict(perfcnt_arb_conflict)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive the handshake-level inputs, then let the combinational paths settle.
  task automatic apply_stimulus(input logic ireq, input logic dreq, input logic aok,
                                input logic dok, input logic [31:0] rdata);
    inst_req    = ireq;
    data_req    = dreq;
    bus_addr_ok = aok;
    bus_data_ok = dok;
    bus_rdata   = rdata;
    #1;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    resetn       = 1'b0;
    inst_cache   = 1'b0;
    inst_addr    = 32'd0;
    data_wr      = 1'b0;
    data_size    = 2'd0;
    data_addr    = 32'd0;
    data_wdata   = 32'd0;
    data_cache   = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    #2;

    // Reset state
    check_output("rst_bus_req", bus_req, 32'd0);
    check_output("rst_inst_addr_ok", inst_addr_ok, 32'd0);
    check_output("rst_data_data_ok", data_data_ok, 32'd0);
    check_output("rst_proto_err", proto_err, 32'd0);
    check_output("rst_perfcnt", perfcnt_arb_conflict, 32'd0);
    check_output("rst_count", 32'(dut.count), 32'd0);

    @(negedge clk);
    resetn = 1'b1;
    next_cycle();

    // Single inst fetch with same-cycle accept, then its response
    inst_addr  = 32'h1fc00000;
    inst_cache = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    check_output("t1_inst_addr_ok", inst_addr_ok, 32'd1);
    check_output("t1_bus_req", bus_req, 32'd1);
    check_output("t1_bus_size", bus_size, 32'd2);
    check_output("t1_bus_wr", bus_wr, 32'd0);
    check_output("t1_bus_addr", bus_addr, 32'h1fc00000);
    check_output("t1_bus_cache", bus_cache, 32'd1);
    check_output("t1_data_addr_ok", data_addr_ok, 32'd0);
    next_cycle();
    check_output("t1_count_after_issue", 32'(dut.count), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h3c1a0000);
    check_output("t1_inst_data_ok", inst_data_ok, 32'd1);
    check_output("t1_data_data_ok", data_data_ok, 32'd0);
    check_output("t1_inst_rdata", inst_rdata, 32'h3c1a0000);
    next_cycle();
    check_output("t1_count_after_resp", 32'(dut.count), 32'd0);

    // Both request for 5 cycles: data wins 4 times, then inst wins. The 5th
    // cycle finds the FIFO full, so a response is returned alongside it.
    inst_addr  = 32'h1fc00004;
    data_addr  = 32'h80001000;
    data_wr    = 1'b1;
    data_size  = 2'd1;
    data_wdata = 32'hdeadbeef;
    data_cache = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b1, (i == 4), 32'h11110000 + 32'(i));
      check_output($sformatf("t2_data_addr_ok_%0d", i), data_addr_ok, 32'(i < 4));
      check_output($sformatf("t2_inst_addr_ok_%0d", i), inst_addr_ok, 32'(i == 4));
      if (i == 0) begin
        check_output("t2_bus_addr_data", bus_addr, 32'h80001000);
        check_output("t2_bus_wr_data", bus_wr, 32'd1);
        check_output("t2_bus_size_data", bus_size, 32'd1);
        check_output("t2_bus_wdata_data", bus_wdata, 32'hdeadbeef);
      end
      if (i == 4) begin
        check_output("t2_bus_addr_inst", bus_addr, 32'h1fc00004);
        check_output("t2_bus_wdata_inst", bus_wdata, 32'd0);
        check_output("t2_pop_with_push", data_data_ok, 32'd1);
      end
      next_cycle();
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_output("t2_perfcnt", perfcnt_arb_conflict, 32'd5);
    check_output("t2_count_full", 32'(dut.count), 32'd4);
    // Remaining owners in order: data, data, data, inst
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h22220000 + 32'(i));
      check_output($sformatf("t2_drain_data_ok_%0d", i), data_data_ok, 32'(i < 3));
      check_output($sformatf("t2_drain_inst_ok_%0d", i), inst_data_ok, 32'(i == 3));
      next_cycle();
    end
    check_output("t2_count_drained", 32'(dut.count), 32'd0);

    // Grant held on inst while the bus stalls; data must wait
    inst_addr = 32'h1fc00100;
    data_addr = 32'h80002000;
    data_wr   = 1'b0;
    data_size = 2'd2;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_output("t3_bus_req", bus_req, 32'd1);
    check_output("t3_bus_addr_c1", bus_addr, 32'h1fc00100);
    check_output("t3_inst_addr_ok_c1", inst_addr_ok, 32'd0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      check_output($sformatf("t3_hold_bus_addr_%0d", i), bus_addr, 32'h1fc00100);
      check_output($sformatf("t3_hold_data_addr_ok_%0d", i), data_addr_ok, 32'd0);
      check_output($sformatf("t3_hold_bus_req_%0d", i), bus_req, 32'd1);
      next_cycle();
    end
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    check_output("t3_inst_addr_ok", inst_addr_ok, 32'd1);
    check_output("t3_data_addr_ok_blocked", data_addr_ok, 32'd0);
    next_cycle();
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    check_output("t3_data_addr_ok", data_addr_ok, 32'd1);
    check_output("t3_bus_addr_data", bus_addr, 32'h80002000);
    check_output("t3_perfcnt_unchanged", perfcnt_arb_conflict, 32'd5);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'haaaa0001);
    check_output("t3_resp_inst", inst_data_ok, 32'd1);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hbbbb0002);
    check_output("t3_resp_data", data_data_ok, 32'd1);
    check_output("t3_data_rdata", data_rdata, 32'hbbbb0002);
    next_cycle();

    // Fill the FIFO, block the 5th request, then accept it alongside a pop
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      check_output($sformatf("t4_fill_addr_ok_%0d", i), data_addr_ok, 32'd1);
      next_cycle();
    end
    check_output("t4_count_full", 32'(dut.count), 32'd4);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    check_output("t4_full_bus_req", bus_req, 32'd0);
    check_output("t4_full_addr_ok", data_addr_ok, 32'd0);
    next_cycle();
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hcccc0003);
    check_output("t4_pop_bus_req", bus_req, 32'd1);
    check_output("t4_pop_addr_ok", data_addr_ok, 32'd1);
    check_output("t4_pop_data_ok", data_data_ok, 32'd1);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_output("t4_count_stays_full", 32'(dut.count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      check_output($sformatf("t4_drain_%0d", i), data_data_ok, 32'd1);
      next_cycle();
    end
    check_output("t4_count_drained", 32'(dut.count), 32'd0);

    // In-order routing inst, data, inst, then a stray response
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    check_output("t5_issue_inst0", inst_addr_ok, 32'd1);
    next_cycle();
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    check_output("t5_issue_data", data_addr_ok, 32'd1);
    next_cycle();
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    check_output("t5_issue_inst1", inst_addr_ok, 32'd1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h55550000 + 32'(i));
      check_output($sformatf("t5_inst_ok_%0d", i), inst_data_ok, 32'(i != 1));
      check_output($sformatf("t5_data_ok_%0d", i), data_data_ok, 32'(i == 1));
      next_cycle();
    end
    check_output("t5_proto_err_before", proto_err, 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    check_output("t5_stray_inst_ok", inst_data_ok, 32'd0);
    check_output("t5_stray_data_ok", data_data_ok, 32'd0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_output("t5_proto_err", proto_err, 32'd1);
    next_cycle();
    check_output("t5_proto_err_sticky", proto_err, 32'd1);

    // Reset while HOLD_D with two outstanding requests
    data_addr = 32'h80003000;
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      next_cycle();
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    check_output("t6_count_two", 32'(dut.count), 32'd2);
    next_cycle();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    check_output("t6_hold_d_addr", bus_addr, 32'h80003000);
    check_output("t6_hold_d_bus_req", bus_req, 32'd1);
    resetn = 1'b0;
    #1;
    check_output("t6_rst_bus_req", bus_req, 32'd0);
    check_output("t6_rst_data_addr_ok", data_addr_ok, 32'd0);
    check_output("t6_rst_count", 32'(dut.count), 32'd0);
    check_output("t6_rst_proto_err", proto_err, 32'd0);
    check_output("t6_rst_perfcnt", perfcnt_arb_conflict, 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'd0);
    check_output("t6_rst_data_ok", data_data_ok, 32'd0);
    resetn = 1'b1;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    check_output("t6_idle_data_addr_ok", data_addr_ok, 32'd1);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_output("t6_count_after", 32'(dut.count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the core's single SRAM-like memory request port between the instruction fetch stage and the data memory stage.
- Picks one requester per request handshake and holds that grant until bus_addr_ok.
- Records the owner of every accepted request in an in-order tag FIFO and routes each bus_data_ok/bus_rdata back to that owner.
- Sits between the core stages and the cache/AXI bridge; also provides an arbitration-conflict performance counter.

Parameters:
MAX_OUTSTANDING, 4, max accepted-but-unanswered requests (tag FIFO depth, power of 2, ≥2)
STARVE_LIMIT, 4, consecutive lost arbitrations after which inst wins the next grant

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request, held until inst_addr_ok
inst_cache  in  1  fetch cacheable attribute
inst_addr  in  32  fetch physical address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_rdata  out  32  fetch read data
inst_data_ok  out  1  fetch response this cycle
data_req  in  1  data request, held until data_addr_ok
data_wr  in  1  1=store
data_size  in  2  0=byte,1=half,2=word
data_addr  in  32  data physical address
data_wdata  in  32  store data
data_cache  in  1  data cacheable attribute
data_addr_ok  out  1  data request accepted this cycle
data_rdata  out  32  data read data
data_data_ok  out  1  data response this cycle
bus_req  out  1  merged request
bus_wr  out  1  merged write flag (0 for inst)
bus_size  out  2  merged size (2 for inst)
bus_addr  out  32  merged address
bus_wdata  out  32  merged write data (0 for inst)
bus_cache  out  1  merged cacheable attribute
bus_addr_ok  in  1  bus accepts request
bus_rdata  in  32  bus response data
bus_data_ok  in  1  bus response, strictly in issue order
proto_err  out  1  sticky: bus_data_ok with empty FIFO
perfcnt_arb_conflict  out  32  cycles where inst and data both request in IDLE

Behaviour:
- Async reset (resetn=0): FSM=IDLE, FIFO empty (count=0, pointers=0), starve counter=0, proto_err=0, perfcnt=0. All outputs derived from cleared state, so addr_ok/data_ok/bus_req=0. Responses in flight at reset are discarded; the bus side is reset with the same signal.
- FSM states and grant owner:
  - IDLE: no locked grant.
  - HOLD_I: grant locked to inst.
  - HOLD_D: grant locked to data.
- issue_ok = (count < MAX_OUTSTANDING) || bus_data_ok. Same-cycle pop frees a slot.
- IDLE grant:
  - Only one requester active: that requester.
  - Both active: data wins, unless starve counter == STARVE_LIMIT, then inst wins.
  - No grant if !issue_ok.
- bus_req = granted requester's req && issue_ok. bus_* payload is muxed from the granted requester; inst payload is wr=0, size=2, wdata=0.
- Handshake and transitions:
  - Handshake = bus_req && bus_addr_ok. It asserts the granted side's addr_ok combinationally in the same cycle, pushes the owner tag (0=inst, 1=data), and the FSM returns to/stays in IDLE.
  - Grant but no handshake: go to HOLD_I/HOLD_D.
  - In HOLD_x the grant stays with x regardless of the other requester. The other side's addr_ok stays 0.
  - If the held requester drops req (protocol violation), bus_req drops and the FSM returns to IDLE next cycle.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each IDLE cycle where data is granted while inst_req=1.
  - Clears on any inst handshake.
- Response path:
  - On bus_data_ok with count>0: pop head tag; the head owner's data_ok=1 that cycle; both rdata outputs = bus_rdata.
  - Push and pop in the same cycle leave count unchanged.
  - On bus_data_ok with count==0: ignore, set proto_err (cleared only by reset).
- Pointers wrap modulo MAX_OUTSTANDING. count is log2(MAX)+1 bits wide and never exceeds MAX.
- perfcnt_arb_conflict increments each IDLE cycle with inst_req && data_req, wrapping at 2^32.
- Latency: zero-cycle combinational request pass-through; zero-cycle response routing. No registered data on either path.

Test Plan:
- Only inst_req=1, addr 0x1fc00000, bus_addr_ok=1 → same-cycle inst_addr_ok=1, bus_size=2, bus_wr=0. Later bus_data_ok with rdata 0x3c1a0000 → inst_data_ok=1, data_data_ok=0.
- Both req in IDLE, bus_addr_ok=1 for 5 cycles, inst held throughout → data granted 4 times, 5th grant to inst (STARVE_LIMIT=4). perfcnt_arb_conflict=5.
- inst granted with bus_addr_ok=0 for 3 cycles, data_req rises in cycle 2 → FSM in HOLD_I, bus_addr stays inst_addr, data_addr_ok=0 until after the inst handshake.
- Issue 4 requests without responses → count=4, 5th request gets bus_req=0. Assert bus_data_ok together with the 5th → request accepted, count stays 4.
- Issue inst, data, inst, then 3 bus_data_ok → data_ok routed inst, data, inst in order. An extra bus_data_ok → proto_err=1.
- Drop resetn mid-HOLD_D with 2 outstanding → immediately bus_req=0, count=0, FSM IDLE, proto_err=0.
